// File: rtl/bank_load_sequencer_if.sv
// Bundle of descriptor, bank-read and destination-write signals around the bank load sequencer.
// Port summary: launch descriptor (start/src/dst/base/count), bank read side (REN_n x2, addr, Q),
// destination side (L0/IFIFO strobes and readies, write data), status (bank_selector, busy, done).
// slave = the sequencer itself; master = controller, SRAM banks and destinations driving it.
interface bank_load_sequencer_if #(
  parameter int bw         = 4,
  parameter int row        = 8,
  parameter int addr_width = 8
);
  // descriptor from the main controller
  logic                  start_i;
  logic                  src_sel_i;
  logic                  dst_sel_i;
  logic [addr_width-1:0] base_addr_i;
  logic [addr_width-1:0] count_i;

  // SRAM bank side
  logic [bw*row-1:0]     bank_data_i;
  logic                  x_bank_read_en_n_o;
  logic                  w_bank_read_en_n_o;
  logic [addr_width-1:0] bank_read_addr_o;

  // destination side
  logic                  l0_wr_ready_i;
  logic                  ififo_wr_ready_i;
  logic                  l0_wr_en_o;
  logic                  ififo_wr_en_o;
  logic [bw*row-1:0]     wr_data_o;

  // status
  logic                  bank_selector_o;
  logic                  busy_o;
  logic                  done_o;

  modport slave (
    input  start_i, src_sel_i, dst_sel_i, base_addr_i, count_i,
           bank_data_i, l0_wr_ready_i, ififo_wr_ready_i,
    output x_bank_read_en_n_o, w_bank_read_en_n_o, bank_read_addr_o,
           l0_wr_en_o, ififo_wr_en_o, wr_data_o,
           bank_selector_o, busy_o, done_o
  );

  modport master (
    output start_i, src_sel_i, dst_sel_i, base_addr_i, count_i,
           bank_data_i, l0_wr_ready_i, ififo_wr_ready_i,
    input  x_bank_read_en_n_o, w_bank_read_en_n_o, bank_read_addr_o,
           l0_wr_en_o, ififo_wr_en_o, wr_data_o,
           bank_selector_o, busy_o, done_o
  );
endinterface

// File: rtl/bank_load_sequencer.sv
// Purpose: moves count vectors from x_bank/w_bank (base..base+count-1, wrapping) into L0 or IFIFO.
// Latency: first write one cycle after first read; 1 vector/cycle while ready; done the cycle after last write.
// Backpressure: a returning vector that meets ready=0 parks in a one-entry hold; reads pause until it drains.
// Ports: clk, reset (async, active high) plus the slave modport of bank_load_sequencer_if:
//   descriptor in (start_i, src_sel_i, dst_sel_i, base_addr_i, count_i), bank REN_n/addr out,
//   bank_data_i in, L0/IFIFO write strobes + data out with their ready inputs, bank_selector/busy/done out.
module bank_load_sequencer #(
  parameter int bw         = 4,
  parameter int row        = 8,
  parameter int addr_width = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  bank_load_sequencer_if.slave        bus
);

  localparam int vw = bw * row;

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_run  = 2'd1;
  localparam logic [1:0] st_done = 2'd2;

  localparam logic [addr_width:0] one_c = {{addr_width{1'b0}}, 1'b1};

  logic [1:0]            state;

  // latched descriptor
  logic                  src_sel_q;
  logic                  dst_sel_q;
  logic [addr_width-1:0] base_q;
  logic [addr_width:0]   count_q;

  // one extra bit so count = 2^addr_width - 1 never overflows the compare
  logic [addr_width:0]   issued_q;
  logic [addr_width:0]   written_q;

  logic [addr_width-1:0] addr_q;
  logic                  inflight_q;
  logic                  hold_vld_q;
  logic [vw-1:0]         hold_dat_q;

  logic                  running;
  logic                  rdy;
  logic                  issue;
  logic                  wr;
  logic [addr_width-1:0] issue_addr;
  logic [addr_width:0]   written_nxt;
  logic [vw-1:0]         wr_dat;

  always_comb begin
    running     = (state == st_run);
    rdy         = dst_sel_q ? bus.ififo_wr_ready_i : bus.l0_wr_ready_i;
    // Reads only go out when the destination can take the returning vector
    // next cycle in the common case, and never while a parked vector waits.
    issue       = running && (issued_q < count_q) && rdy && !hold_vld_q;
    // The hold and the in-flight read are mutually exclusive (issue needs an
    // empty hold), so at most one vector is a write candidate per cycle.
    wr          = running && (hold_vld_q || inflight_q) && rdy;
    issue_addr  = base_q + issued_q[addr_width-1:0];
    written_nxt = wr ? (written_q + one_c) : written_q;
    wr_dat      = '0;
    if (wr) begin
      wr_dat = hold_vld_q ? hold_dat_q : bus.bank_data_i;
    end
  end

  assign bus.x_bank_read_en_n_o = !(issue && !src_sel_q);
  assign bus.w_bank_read_en_n_o = !(issue &&  src_sel_q);
  assign bus.bank_read_addr_o   = issue ? issue_addr : addr_q;
  assign bus.l0_wr_en_o         = wr && !dst_sel_q;
  assign bus.ififo_wr_en_o      = wr &&  dst_sel_q;
  assign bus.wr_data_o          = wr_dat;
  assign bus.bank_selector_o    = src_sel_q;
  assign bus.busy_o             = (state == st_run) || (state == st_done);
  assign bus.done_o             = (state == st_done);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= st_idle;
      src_sel_q  <= 1'b0;
      dst_sel_q  <= 1'b0;
      base_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      written_q  <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_dat_q <= '0;
    end else begin
      inflight_q <= issue;

      if (issue) begin
        addr_q   <= issue_addr;
        issued_q <= issued_q + one_c;
      end

      if (wr) begin
        written_q <= written_nxt;
      end

      // A vector arriving while the destination stalls is parked; SRAM Q is
      // not guaranteed to hold it past this cycle.
      if (inflight_q && !rdy) begin
        hold_vld_q <= 1'b1;
        hold_dat_q <= bus.bank_data_i;
      end else if (hold_vld_q && wr) begin
        hold_vld_q <= 1'b0;
      end

      case (state)
        st_idle: begin
          if (bus.start_i) begin
            src_sel_q <= bus.src_sel_i;
            dst_sel_q <= bus.dst_sel_i;
            base_q    <= bus.base_addr_i;
            count_q   <= {1'b0, bus.count_i};
            issued_q  <= '0;
            written_q <= '0;
            state     <= (bus.count_i == '0) ? st_done : st_run;
          end
        end
        st_run: begin
          // Looking at the post-write count lets done land the cycle after the last write.
          if (written_nxt == count_q) begin
            state <= st_done;
          end
        end
        st_done: begin
          state <= st_idle;
        end
        default: begin
          state <= st_idle;
        end
      endcase
    end
  end

  // Structural invariants of the hold/in-flight scheme.
  a_hold_excl: assert property (@(posedge clk) disable iff (reset) !(hold_vld_q && inflight_q));
  a_one_strb:  assert property (@(posedge clk) disable iff (reset) !(bus.l0_wr_en_o && bus.ififo_wr_en_o));
  a_no_over:   assert property (@(posedge clk) disable iff (reset) (written_q <= issued_q));

endmodule

// File: doc/bank_load_sequencer.md
Name: bank_load_sequencer

Overview:
Sequences bulk transfers of activation or weight vectors from x_bank or w_bank into the corelet L0 or IFIFO. It issues SRAM reads, absorbs the 1-cycle SRAM read latency, and honours destination back-pressure through a one-entry hold register. The main controller launches it with a start pulse and a descriptor (source, destination, base address, count), then waits for done.

Parameters:
bw, 4, bits per element
row, 8, elements per vector (vector width = bw*row)
addr_width, 8, bank address width and count width

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
start_i  input  1  launch pulse; sampled only in IDLE
src_sel_i  input  1  0 = x_bank, 1 = w_bank
dst_sel_i  input  1  0 = L0, 1 = IFIFO
base_addr_i  input  addr_width  first bank address
count_i  input  addr_width  number of vectors to move
bank_data_i  input  bw*row  SRAM Q of the selected bank
l0_wr_ready_i  input  1  L0 can accept a vector this cycle
ififo_wr_ready_i  input  1  IFIFO can accept a vector this cycle
x_bank_read_en_n_o  output  1  x_bank REN, active low
w_bank_read_en_n_o  output  1  w_bank REN, active low
bank_read_addr_o  output  addr_width  read address to both banks
l0_wr_en_o  output  1  write strobe to L0
ififo_wr_en_o  output  1  write strobe to IFIFO
wr_data_o  output  bw*row  vector to the destination
bank_selector_o  output  1  latched src_sel, drives the corelet input mux
busy_o  output  1  transfer in progress
done_o  output  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, active high): both read_en_n = 1; addr = 0; both wr_en = 0; wr_data = 0; bank_selector = 0; busy = 0; done = 0. Reset mid-transfer clears all state immediately. The partial transfer is abandoned and no done pulse is produced.
- States:
  - IDLE -> RUN on start_i with count_i != 0.
  - IDLE -> DONE on start_i with count_i == 0 (no reads issued).
  - RUN -> DONE when written == count.
  - DONE -> IDLE after 1 cycle.
- Descriptor handling: the descriptor is latched on the start cycle. start_i outside IDLE is ignored. busy_o = 1 in RUN and DONE.
- Let rdy = dst_sel ? ififo_wr_ready_i : l0_wr_ready_i.
- Read issue in cycle t requires all of: RUN, issued < count, rdy = 1, hold empty.
  - On issue, drive the selected bank's read_en_n = 0 and bank_read_addr_o = base + issued (mod 2^addr_width; wraps past max address).
  - The unselected bank's read_en_n stays 1.
  - When not issuing, bank_read_addr_o holds its last value.
- Data return: data for an issue in cycle t is valid on bank_data_i in cycle t+1 (inflight = 1).
- Write, combinational, in a cycle where (hold valid or inflight) and rdy:
  - Assert the selected wr_en (exactly one).
  - wr_data_o = hold valid ? hold register : bank_data_i.
  - Increment written.
- Write priority: hold data is written before inflight data. Hold and inflight are never both valid, because issue requires hold empty.
- Stall: if inflight and rdy = 0 in t+1, capture bank_data_i into the hold register. No issue occurs until the hold register has drained.
- No-write cycles: wr_data_o = 0 and both wr_en = 0.
- Throughput: 1 vector per cycle while rdy stays high. First write occurs 1 cycle after the first issue. done_o pulses in the cycle after the last write.
- Ordering: vectors are delivered strictly in address order, with no duplicates or drops under any ready pattern.
- Counters are addr_width+1 bits wide, so count = 2^addr_width - 1 is handled without overflow.

Test Plan:
- Basic x_bank to L0: src=0, dst=0, base=0x10, count=4, l0_ready always 1 -> reads 0x10..0x13 on consecutive cycles; 4 L0 writes in order, each one cycle after its read; done pulses 1 cycle after the 4th write; w_bank REN stays 1.
- Back-pressure: w_bank to IFIFO, base=0, count=3, ififo_ready dropped for 3 cycles in the cycle data returns -> vector captured in hold, no new read issued while held; all 3 vectors delivered in order, no duplicate or lost vector.
- Address wrap: base=0xFE, count=4 -> read addresses 0xFE, 0xFF, 0x00, 0x01.
- Zero count: start with count=0 -> no REN low, no wr_en; busy high 1 cycle; done pulses the cycle after start.
- Ignored start: start pulsed while busy with a different descriptor -> current transfer unaffected; second start has no effect.
- Reset mid-transfer: assert reset after 2 of 6 writes -> outputs immediately at reset values, no done pulse; a fresh start then completes normally.
